// File: rtl/hex_display_pkg.sv
// hex_display_pkg: active-low seven-segment patterns and scan-index sizing for hex_display_scanner
package hex_display_pkg;
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_TABLE [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                              SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
    function automatic int scan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex digit to active-low {g,f,e,d,c,b,a} segment decoder
module hex_to_seg
    import hex_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: keypad digit shift register driving a multiplexed common-anode 7-seg display
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            hex_in,
    input  logic                  hex_valid,
    input  logic                  clear,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] an_n
);
    localparam int SW = scan_width(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);
    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [PW-1:0]              presc;
    logic [SW-1:0]              scan_idx;
    logic                       valid_q;
    logic                       tick;
    logic                       blank;
    logic [3:0]                 cur;
    logic [6:0]                 seg;
    assign tick = presc == PW'(REFRESH_DIV - 1);
    assign cur  = digits[scan_idx];
    hex_to_seg u_dec (.hex(cur), .seg(seg));
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    always_comb begin
        lead_zero = '0;
        lead_zero[NUM_DIGITS-1] = digits[NUM_DIGITS-1] == 4'h0;
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            lead_zero[i] = lead_zero[i+1] && digits[i] == 4'h0;
    end
    assign blank = scan_idx != '0 && lead_zero[scan_idx];
`else
    assign blank = 1'b0;
`endif
    // The tick cycle is blanked so the old pattern never flashes on the next anode
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digits   <= '0;
            presc    <= '0;
            scan_idx <= '0;
            valid_q  <= 1'b0;
            seg_n    <= SEG_BLANK;
            an_n     <= '1;
        end else begin
            valid_q <= hex_valid;
            presc   <= tick ? '0 : presc + 1'b1;
            if (tick)
                scan_idx <= (scan_idx == SW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            if (clear)
                digits <= '0;
            else if (hex_valid && !valid_q)
                digits <= {digits[NUM_DIGITS-2:0], hex_in};
            an_n  <= tick ? '1 : ~(NUM_DIGITS'(1) << scan_idx);
            seg_n <= (tick || blank) ? SEG_BLANK : seg;
        end
    end
endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Display-side counterpart to the keypad hex encoder.
- Captures 4-bit hex codes from the keypad path into a calculator-style shift register of NUM_DIGITS digits.
- Drives a multiplexed, common-anode seven-segment display: one digit at a time, selected by a prescaled scan counter.
- Sits between the keypad encoder output and the board's segment/anode pins.

Parameters:
- NUM_DIGITS, 4, number of display digits (2..8).
- REFRESH_DIV, 100000, clock cycles each digit stays lit (>= 2).

Ports:
- clock  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- hex_in  input  4  hex code from keypad encoder.
- hex_valid  input  1  key-press strobe; its rising edge captures hex_in.
- clear  input  1  synchronous clear of all stored digits.
- seg_n  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
- an_n  output  NUM_DIGITS  active-low digit enables, registered; bit 0 = rightmost digit.

Behaviour:
- Reset (async) state:
  - all digit registers = 0, prescaler = 0, scan_idx = 0, valid_q = 0.
  - seg_n = 7'h7F, an_n = all ones (display dark).
- Entry:
  - valid_q <= hex_valid every cycle.
  - A shift fires only when hex_valid=1 and valid_q=0, i.e. once per press however long the strobe is held.
  - On a shift: digit[i] <= digit[i-1] for i>0, digit[0] <= hex_in. The oldest digit falls off the left end.
- clear:
  - Zeroes all digits on the next edge.
  - Beats a simultaneous shift; valid_q still updates, so a press held across clear does not re-fire.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = 1 when the count is REFRESH_DIV-1.
- Scan:
  - On tick, scan_idx advances by 1, wrapping NUM_DIGITS-1 -> 0.
  - Width is $clog2(NUM_DIGITS), minimum 1.
- Outputs (registered, 1-cycle latency from scan_idx/digit state):
  - Tick cycle: an_n <= all ones and seg_n <= 7'h7F. This one-cycle anti-ghost blank prevents the old pattern flashing on the new anode.
  - Otherwise: an_n <= ~(1 << scan_idx) and seg_n <= decode(digit[scan_idx]).
- Decode table, hex value -> seg_n:
  - 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->78
  - 8->00, 9->10, A->08, b->03, C->46, d->21, E->06, F->0E
- Digit-register update timing: a shift is visible on seg_n 1 cycle after the register changes, provided the changed digit is the one being scanned.
- Reset mid-scan: everything returns to reset values at once; scanning restarts at digit 0 after deassertion.
- First cycle after reset release: an_n = ~1, seg_n = 7'h40.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit i (i > 0) is blanked (seg_n = 7'h7F, anode still driven normally) when digit[i] and every higher digit are 0.
  - Digit 0 is never blanked.
  - Blank status is computed from the current digit registers, with the same 1-cycle latency as the segment output.
- Undefined: all digits are always shown, including leading zeros.

Decomposition:
- Package hex_display_pkg:
  - 16 active-low segment constants (SEG_0..SEG_F).
  - SEG_BLANK = 7'h7F.
  - Scan-index width helper.
- Sub-module hex_to_seg: purely combinational, 4-bit in, 7-bit active-low out, using the package constants.
- The top level holds the prescaler, scan counter, digit shift register, edge detect and output registers.

Test Plan (REFRESH_DIV=4, NUM_DIGITS=4):
- Reset released with no input -> an_n walks E,D,B,7 with a one-cycle F blank at each tick; seg_n = 40 on all lit cycles.
- Press sequence 1,2,3,4 (hex_valid pulses) -> stored digits 3..0 = 1,2,3,4; digit 0 lit shows seg_n=19, digit 3 lit shows seg_n=79.
- hex_valid held high 10 cycles with hex_in=A -> exactly one shift; digit 0 = A, seg_n=08 when an_n=E.
- Five presses 1,2,3,4,5 -> digits = 2,3,4,5; the 1 has been discarded.
- clear and hex_valid rising in the same cycle -> all digits 0, no shift; seg_n=40 on every digit.
- Async reset asserted mid-scan at scan_idx=2 -> seg_n=7F and an_n=F immediately, not at the next clock edge; with LEADING_ZERO_BLANK_EN and a single press of 7, digits 3..1 show 7F and digit 0 shows 78.
